// File: rtl/boreal_vec_pkg.sv
// Shared definitions for the boreal vector lane and its upstream sequencer:
// lane operation codes and the sequencer state encoding.
package boreal_vec_pkg;

   // Operation codes understood by boreal_vec_lane
   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_MAC      = 3'd1,
      OP_SCALE    = 3'd2,
      OP_CLAMP    = 3'd3,
      OP_ZERO_ACC = 3'd5
   } lane_op_e;

   // Dot-product sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ZERO  = 3'd1,
      ST_MAC   = 3'd2,
      ST_SCALE = 3'd3,
      ST_CLAMP = 3'd4,
      ST_CAPT  = 3'd5,
      ST_OUT   = 3'd6
   } seq_state_e;

endpackage

// File: rtl/boreal_vec_dot_seq.sv
// Dot-product sequencer for one boreal_vec_lane. Accepts a command, walks the
// lane through ZERO_ACC -> MAC xK -> SCALE -> CLAMP, captures the clamped
// accumulator and hands it out over a valid/ready result port.
module boreal_vec_dot_seq
   import boreal_vec_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [15:0]        cmd_scale,
   input  logic [15:0]        cmd_zero_pt,
   input  logic [31:0]        cmd_clamp_min,
   input  logic [31:0]        cmd_clamp_max,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [7:0]         op_a,
   input  logic [7:0]         op_b,
   output logic               lane_en,
   output logic [2:0]         lane_op,
   output logic [7:0]         lane_a,
   output logic [7:0]         lane_b,
   output logic [15:0]        lane_scale,
   output logic [15:0]        lane_zero_pt,
   output logic [31:0]        lane_clamp_min,
   output logic [31:0]        lane_clamp_max,
   input  logic [31:0]        lane_acc,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [31:0]        res_data,
   output logic               busy,
   output logic [STALL_W-1:0] stall_cnt
);

   seq_state_e         state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        scale_q, scale_d;
   logic [15:0]        zp_q, zp_d;
   logic [31:0]        cmin_q, cmin_d;
   logic [31:0]        cmax_q, cmax_d;
   logic [31:0]        res_q, res_d;
   logic [STALL_W-1:0] stall_q, stall_d;

   // Next-state and datapath update for the sequencer
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      scale_d = scale_q;
      zp_d    = zp_q;
      cmin_d  = cmin_q;
      cmax_d  = cmax_q;
      res_d   = res_q;
      stall_d = stall_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_ZERO;
               len_d   = cmd_len;
               scale_d = cmd_scale;
               zp_d    = cmd_zero_pt;
               cmin_d  = cmd_clamp_min;
               cmax_d  = cmd_clamp_max;
               cnt_d   = {LEN_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ZERO: begin
            // An empty dot product skips straight to requantisation of zero
            if (len_q == {LEN_W{1'b0}}) begin
               state_d = ST_SCALE;
            end else begin
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (op_valid) begin
               if (cnt_q == (len_q - LEN_W'(1))) begin
                  state_d = ST_SCALE;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end else if (stall_q != {STALL_W{1'b1}}) begin
               stall_d = stall_q + STALL_W'(1);
            end else begin
               stall_d = stall_q;
            end
         end
         ST_SCALE: state_d = ST_CLAMP;
         ST_CLAMP: state_d = ST_CAPT;
         ST_CAPT: begin
            // Lane register already holds the clamp result at this point
            res_d   = lane_acc;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and latched-field registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= {LEN_W{1'b0}};
         cnt_q   <= {LEN_W{1'b0}};
         scale_q <= 16'd0;
         zp_q    <= 16'd0;
         cmin_q  <= 32'd0;
         cmax_q  <= 32'd0;
         res_q   <= 32'd0;
         stall_q <= {STALL_W{1'b0}};
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         scale_q <= scale_d;
         zp_q    <= zp_d;
         cmin_q  <= cmin_d;
         cmax_q  <= cmax_d;
         res_q   <= res_d;
         stall_q <= stall_d;
      end
   end

   // Lane control and handshake outputs decoded from the current state
   always_comb begin
      lane_en   = 1'b0;
      lane_op   = OP_NOP;
      op_ready  = 1'b0;
      cmd_ready = 1'b0;
      case (state_q)
         ST_IDLE: cmd_ready = 1'b1;
         ST_ZERO: begin
            lane_en = 1'b1;
            lane_op = OP_ZERO_ACC;
         end
         ST_MAC: begin
            op_ready = 1'b1;
            lane_en  = op_valid;
            lane_op  = OP_MAC;
         end
         ST_SCALE: begin
            lane_en = 1'b1;
            lane_op = OP_SCALE;
         end
         ST_CLAMP: begin
            lane_en = 1'b1;
            lane_op = OP_CLAMP;
         end
         ST_CAPT: lane_en = 1'b0;
         ST_OUT:  lane_en = 1'b0;
         default: lane_en = 1'b0;
      endcase
   end

   assign lane_a         = op_a;
   assign lane_b         = op_b;
   assign lane_scale     = scale_q;
   assign lane_zero_pt   = zp_q;
   assign lane_clamp_min = cmin_q;
   assign lane_clamp_max = cmax_q;
   assign res_valid      = (state_q == ST_OUT);
   assign res_data       = res_q;
   assign busy           = (state_q != ST_IDLE);
   assign stall_cnt      = stall_q;

endmodule
